// File: rtl/sum_diff_decoder.sv
// sum_diff_decoder
//   Recovers a = (s + d) / 2 and b = (s - d) / 2 from a fixed-point
//   sum/difference pair. Every value is significand * 2^exponent, and the
//   exponents are fixed when the module is elaborated. The datapath is two
//   register stages with valid/ready handshaking on both sides.
//
//   Stage 1 aligns s and d to a common exponent and registers their sum and
//   difference.
//   Stage 2 rescales both results to the a/b formats, flooring toward -inf,
//   and saturates them to the output widths.
//
// Ports
//   clk, rst             clock (rising edge); asynchronous active-high reset
//   in_valid / in_ready  input handshake for the s/d pair
//   s_in, d_in           signed sum / difference significands
//   out_valid / out_ready output handshake for the a/b pair
//   a_out, b_out         signed recovered significands
//   sat_a, sat_b         sticky saturation flags
//   clr_sat              synchronous clear of both flags; a new clamp in the
//                        same cycle takes priority over the clear
module sum_diff_decoder #(
  parameter int S_WIDTH = 18,
  parameter int S_EXP   = -10,
  parameter int D_WIDTH = 19,
  parameter int D_EXP   = -11,
  parameter int A_WIDTH = 16,
  parameter int A_EXP   = -8,
  parameter int B_WIDTH = 17,
  parameter int B_EXP   = -9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [S_WIDTH-1:0] s_in,
  input  logic signed [D_WIDTH-1:0] d_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [A_WIDTH-1:0] a_out,
  output logic signed [B_WIDTH-1:0] b_out,
  output logic                      sat_a,
  output logic                      sat_b,
  input  logic                      clr_sat
);

  // Common exponent and the lossless alignment shifts that reach it.
  localparam int E_C  = (S_EXP < D_EXP) ? S_EXP : D_EXP;
  localparam int SH_S = S_EXP - E_C;
  localparam int SH_D = D_EXP - E_C;
  localparam int WS   = S_WIDTH + SH_S;
  localparam int WD   = D_WIDTH + SH_D;
  localparam int W_I  = ((WS > WD) ? WS : WD) + 1;

  // Output rescale. The extra +1 in the shift is the divide by two. A
  // positive shift is an arithmetic right shift; a negative one becomes a
  // left shift inside a widened intermediate.
  localparam int KA    = A_EXP - E_C + 1;
  localparam int KB    = B_EXP - E_C + 1;
  localparam int SRA_A = (KA > 0) ? KA : 0;
  localparam int SLA_A = (KA < 0) ? -KA : 0;
  localparam int SRA_B = (KB > 0) ? KB : 0;
  localparam int SLA_B = (KB < 0) ? -KB : 0;
  localparam int W_RA  = W_I + SLA_A;
  localparam int W_RB  = W_I + SLA_B;

  // Clamp comparisons run at a width that holds both the raw value and
  // the output range, with at least one spare sign bit.
  localparam int W_CA = ((W_RA > A_WIDTH) ? W_RA : A_WIDTH) + 1;
  localparam int W_CB = ((W_RB > B_WIDTH) ? W_RB : B_WIDTH) + 1;
  localparam logic signed [W_CA-1:0] A_HI = {{(W_CA-A_WIDTH+1){1'b0}}, {(A_WIDTH-1){1'b1}}};
  localparam logic signed [W_CA-1:0] A_LO = {{(W_CA-A_WIDTH+1){1'b1}}, {(A_WIDTH-1){1'b0}}};
  localparam logic signed [W_CB-1:0] B_HI = {{(W_CB-B_WIDTH+1){1'b0}}, {(B_WIDTH-1){1'b1}}};
  localparam logic signed [W_CB-1:0] B_LO = {{(W_CB-B_WIDTH+1){1'b1}}, {(B_WIDTH-1){1'b0}}};

  logic                      v1_q, v1_d, v2_q, v2_d;
  logic                      ld1, ld2;
  logic signed [W_I-1:0]     s_al, d_al, sum_d, dif_d;
  logic signed [W_I-1:0]     r_sum_q, r_dif_q;
  logic signed [W_RA-1:0]    a_raw;
  logic signed [W_RB-1:0]    b_raw;
  logic signed [W_CA-1:0]    a_w;
  logic signed [W_CB-1:0]    b_w;
  logic                      clamp_a, clamp_b;
  logic signed [A_WIDTH-1:0] a_d, a_q;
  logic signed [B_WIDTH-1:0] b_d, b_q;
  logic                      sat_a_d, sat_a_q, sat_b_d, sat_b_q;

  // Stage 1: sign-extend, align, then form the sum and difference. W_I
  // carries one bit of headroom beyond the widest aligned operand, so
  // neither result can overflow.
  always_comb begin
    s_al  = W_I'(s_in) <<< SH_S;
    d_al  = W_I'(d_in) <<< SH_D;
    sum_d = s_al + d_al;
    dif_d = s_al - d_al;
  end

  // Stage 2: rescale, then saturate.
  always_comb begin
    a_raw   = (W_RA'(r_sum_q) >>> SRA_A) <<< SLA_A;
    b_raw   = (W_RB'(r_dif_q) >>> SRA_B) <<< SLA_B;
    a_w     = W_CA'(a_raw);
    b_w     = W_CB'(b_raw);
    clamp_a = (a_w > A_HI) || (a_w < A_LO);
    clamp_b = (b_w > B_HI) || (b_w < B_LO);
    a_d     = a_w[A_WIDTH-1:0];
    b_d     = b_w[B_WIDTH-1:0];
    if (a_w > A_HI) a_d = {1'b0, {(A_WIDTH-1){1'b1}}};
    if (a_w < A_LO) a_d = {1'b1, {(A_WIDTH-1){1'b0}}};
    if (b_w > B_HI) b_d = {1'b0, {(B_WIDTH-1){1'b1}}};
    if (b_w < B_LO) b_d = {1'b1, {(B_WIDTH-1){1'b0}}};
  end

  // Handshake control. Stage 1 also accepts when stage 2 is about to drain
  // into the output, so a full pipeline keeps streaming while out_ready=1.
  assign in_ready = !v1_q || !v2_q || out_ready;

  always_comb begin
    ld1     = in_valid && in_ready;
    ld2     = v1_q && (!v2_q || out_ready);
    v1_d    = ld1 ? 1'b1 : (ld2 ? 1'b0 : v1_q);
    v2_d    = ld2 ? 1'b1 : (out_ready ? 1'b0 : v2_q);
    sat_a_d = (ld2 && clamp_a) || (sat_a_q && !clr_sat);
    sat_b_d = (ld2 && clamp_b) || (sat_b_q && !clr_sat);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      r_sum_q <= '0;
      r_dif_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sat_a_q <= 1'b0;
      sat_b_q <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      sat_a_q <= sat_a_d;
      sat_b_q <= sat_b_d;
      if (ld1) begin
        r_sum_q <= sum_d;
        r_dif_q <= dif_d;
      end
      if (ld2) begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end
  end

  assign out_valid = v2_q;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign sat_a     = sat_a_q;
  assign sat_b     = sat_b_q;

endmodule

// File: tb/tb_sum_diff_decoder.sv
module tb_sum_diff_decoder;

  localparam int S_WIDTH = 18, S_EXP = -10, D_WIDTH = 19, D_EXP = -11;
  localparam int A_WIDTH = 16, A_EXP = -8, B_WIDTH = 17, B_EXP = -9;
  localparam int A2_WIDTH = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic in_valid, in_ready, out_valid, out_ready, sat_a, sat_b, clr_sat;
  logic signed [S_WIDTH-1:0] s_in;
  logic signed [D_WIDTH-1:0] d_in;
  logic signed [A_WIDTH-1:0] a_out;
  logic signed [B_WIDTH-1:0] b_out;

  // Narrow-a instance, used for saturation.
  logic in_valid2, in_ready2, out_valid2, out_ready2, sat_a2, sat_b2, clr_sat2;
  logic signed [S_WIDTH-1:0]  s_in2;
  logic signed [D_WIDTH-1:0]  d_in2;
  logic signed [A2_WIDTH-1:0] a_out2;
  logic signed [B_WIDTH-1:0]  b_out2;

  int checks = 0;
  int errors = 0;

  sum_diff_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s_in(s_in), .d_in(d_in), .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .sat_a(sat_a), .sat_b(sat_b), .clr_sat(clr_sat)
  );

  sum_diff_decoder #(.A_WIDTH(A2_WIDTH)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .s_in(s_in2), .d_in(d_in2), .out_valid(out_valid2), .out_ready(out_ready2),
    .a_out(a_out2), .b_out(b_out2), .sat_a(sat_a2), .sat_b(sat_b2), .clr_sat(clr_sat2)
  );

  // Reference model: the real values of s and d, halved sum/difference,
  // expressed in the output format with floor rounding, then clamped.
  function automatic longint ref_val(input longint s, input longint d, input bit for_a);
    real sv, dv, v;
    sv = real'(s) * (2.0 ** S_EXP);
    dv = real'(d) * (2.0 ** D_EXP);
    v  = for_a ? (sv + dv) / 2.0 : (sv - dv) / 2.0;
    v  = v / (2.0 ** (for_a ? A_EXP : B_EXP));
    return longint'($floor(v));
  endfunction

  function automatic longint clampw(input longint x, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  longint qa[$], qb[$];

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || a_out !== '0 || b_out !== '0 || sat_a !== 1'b0 ||
        sat_b !== 1'b0 || out_valid2 !== 1'b0 || sat_a2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got ov=%b a=%0d b=%0d sa=%b sb=%b exp all 0",
               out_valid, a_out, b_out, sat_a, sat_b);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    s_in = S_WIDTH'(1536); d_in = D_WIDTH'(1024);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency1 got out_valid=%b exp 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || longint'(a_out) != 256 || longint'(b_out) != 256 ||
        sat_a !== 1'b0 || sat_b !== 1'b0) begin
      errors++;
      $display("FAIL basic_decode got v=%b a=%0d b=%0d sa=%b sb=%b exp v=1 a=256 b=256 flags 0",
               out_valid, a_out, b_out, sat_a, sat_b);
    end
  endtask

  task automatic test_negative();
    longint ts[2] = '{-1, 0};
    longint td[2] = '{0, 0};
    longint ea[2] = '{-1, 0};
    longint eb[2] = '{-1, 0};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      s_in = S_WIDTH'(ts[i]); d_in = D_WIDTH'(td[i]);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || longint'(a_out) != ea[i] || longint'(b_out) != eb[i]) begin
        errors++;
        $display("FAIL neg_round[%0d] got v=%b a=%0d b=%0d exp a=%0d b=%0d",
                 i, out_valid, a_out, b_out, ea[i], eb[i]);
      end
    end
  endtask

  task automatic test_saturation();
    out_ready2 = 1'b1; clr_sat2 = 1'b0;
    @(negedge clk);
    in_valid2 = 1'b1; s_in2 = S_WIDTH'(131071); d_in2 = D_WIDTH'(262143);
    @(negedge clk);
    in_valid2 = 1'b0;
    @(negedge clk);
    checks++;
    if (longint'(a_out2) != 2047 || longint'(b_out2) != -1 || sat_a2 !== 1'b1 || sat_b2 !== 1'b0) begin
      errors++;
      $display("FAIL sat_clamp got a=%0d b=%0d sa=%b sb=%b exp a=2047 b=-1 sa=1 sb=0",
               a_out2, b_out2, sat_a2, sat_b2);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sat_a2 !== 1'b1) begin
      errors++;
      $display("FAIL sat_sticky got %b exp 1", sat_a2);
    end
    clr_sat2 = 1'b1;
    @(negedge clk);
    clr_sat2 = 1'b0;
    checks++;
    if (sat_a2 !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear got %b exp 0", sat_a2);
    end
    in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    clr_sat2  = 1'b1;   // same edge as the clamped load into stage 2
    @(negedge clk);
    clr_sat2 = 1'b0;
    checks++;
    if (sat_a2 !== 1'b1) begin
      errors++;
      $display("FAIL sat_set_wins got %b exp 1", sat_a2);
    end
  endtask

  task automatic test_streaming();
    int sent = 0, got = 0, cyc = 0;
    longint ea, eb;
    while (got < 100 && cyc < 400) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (sent < 100);
      s_in = S_WIDTH'($urandom);
      d_in = D_WIDTH'($urandom);
      #1;
      checks++;
      if (out_valid !== (cyc >= 2) || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_rate cyc=%0d got v=%b rdy=%b exp v=%b rdy=1",
                 cyc, out_valid, in_ready, cyc >= 2);
      end
      if (out_valid === 1'b1 && qa.size() > 0) begin
        ea = qa.pop_front(); eb = qb.pop_front();
        got++;
        checks++;
        if (longint'(a_out) != ea || longint'(b_out) != eb) begin
          errors++;
          $display("FAIL stream_data #%0d got a=%0d b=%0d exp a=%0d b=%0d", got, a_out, b_out, ea, eb);
        end
      end
      if (in_valid && in_ready) begin
        qa.push_back(clampw(ref_val(longint'(s_in), longint'(d_in), 1'b1), A_WIDTH));
        qb.push_back(clampw(ref_val(longint'(s_in), longint'(d_in), 1'b0), B_WIDTH));
        sent++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (got != 100 || qa.size() != 0) begin
      errors++;
      $display("FAIL stream_count got %0d left %0d exp 100 left 0", got, qa.size());
    end
  endtask

  task automatic test_backpressure();
    int sent = 0, got = 0, cyc = 0;
    bit stalled = 1'b0, need_new = 1'b1;
    logic signed [A_WIDTH-1:0] pa;
    logic signed [B_WIDTH-1:0] pb;
    longint ea, eb;
    pa = '0; pb = '0;
    while (got < 60 && cyc < 2000) begin
      @(negedge clk);
      in_valid  = (sent < 60);
      out_ready = ($urandom_range(0, 99) < 30);
      if (need_new) begin
        s_in = S_WIDTH'($urandom);
        d_in = D_WIDTH'($urandom);
        need_new = 1'b0;
      end
      #1;
      checks++;
      if (in_ready !== !(qa.size() == 2 && !out_ready) || qa.size() > 2) begin
        errors++;
        $display("FAIL bp_in_ready cyc=%0d got %b buffered=%0d out_ready=%b",
                 cyc, in_ready, qa.size(), out_ready);
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || a_out !== pa || b_out !== pb) begin
          errors++;
          $display("FAIL bp_hold got v=%b a=%0d b=%0d exp v=1 a=%0d b=%0d", out_valid, a_out, b_out, pa, pb);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL bp_spurious got output a=%0d exp none", a_out);
        end else begin
          ea = qa.pop_front(); eb = qb.pop_front();
          got++;
          if (longint'(a_out) != ea || longint'(b_out) != eb) begin
            errors++;
            $display("FAIL bp_data #%0d got a=%0d b=%0d exp a=%0d b=%0d", got, a_out, b_out, ea, eb);
          end
        end
      end
      if (in_valid && in_ready) begin
        qa.push_back(clampw(ref_val(longint'(s_in), longint'(d_in), 1'b1), A_WIDTH));
        qb.push_back(clampw(ref_val(longint'(s_in), longint'(d_in), 1'b0), B_WIDTH));
        sent++;
        need_new = 1'b1;
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      pa = a_out; pb = b_out;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 60 || sent != 60 || qa.size() != 0) begin
      errors++;
      $display("FAIL bp_count got %0d of %0d left %0d exp 60 left 0", got, sent, qa.size());
    end
  endtask

  task automatic test_reset_midstream();
    longint ea, eb;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; s_in = S_WIDTH'(1000); d_in = D_WIDTH'(-3000);
    @(negedge clk);
    s_in = S_WIDTH'(-7777); d_in = D_WIDTH'(5555);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_before_rst got rdy=%b v=%b exp rdy=0 v=1", in_ready, out_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || a_out !== '0 || b_out !== '0 || sat_a !== 1'b0 ||
        sat_b !== 1'b0 || sat_a2 !== 1'b0 || a_out2 !== '0) begin
      errors++;
      $display("FAIL async_rst got v=%b a=%0d b=%0d sa=%b sa2=%b exp all 0",
               out_valid, a_out, b_out, sat_a, sat_a2);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_after_rst got v=%b exp 0", out_valid);
    end
    in_valid = 1'b1; s_in = S_WIDTH'(-20000); d_in = D_WIDTH'(12345);
    ea = clampw(ref_val(-20000, 12345, 1'b1), A_WIDTH);
    eb = clampw(ref_val(-20000, 12345, 1'b0), B_WIDTH);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_latency got v=%b exp 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || longint'(a_out) != ea || longint'(b_out) != eb) begin
      errors++;
      $display("FAIL post_rst_data got v=%b a=%0d b=%0d exp v=1 a=%0d b=%0d", out_valid, a_out, b_out, ea, eb);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; clr_sat = 1'b0; s_in = '0; d_in = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; clr_sat2 = 1'b0; s_in2 = '0; d_in2 = '0;
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_streaming();
    test_backpressure();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
